telemetry_framer: RTL

TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

---
 rtl/telemetry_framer_pkg.sv | 51 +++++
 rtl/telemetry_encoder.sv | 55 +++++
 rtl/telemetry_framer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/telemetry_framer_pkg.sv
// Shared definitions for the telemetry framer.
// Contents: default frame delimiters, the traffic controller's state codes,
// the ASCII characters used in a frame, framer FSM states and a helper that
// turns a nibble into an uppercase ASCII hex digit.
package telemetry_framer_pkg;

  // Frame delimiters
  localparam logic [7:0] SOF_DEFAULT = 8'h24;  // '$'
  localparam logic [7:0] EOL_DEFAULT = 8'h0A;  // LF

  // Controller state codes. 0-7 pair up as green/yellow per direction,
  // 8 is all-red, and 9-12 are the per-direction crossing phases.
  localparam logic [3:0] CTL_N_GREEN  = 4'd0;
  localparam logic [3:0] CTL_N_YELLOW = 4'd1;
  localparam logic [3:0] CTL_S_GREEN  = 4'd2;
  localparam logic [3:0] CTL_S_YELLOW = 4'd3;
  localparam logic [3:0] CTL_E_GREEN  = 4'd4;
  localparam logic [3:0] CTL_E_YELLOW = 4'd5;
  localparam logic [3:0] CTL_W_GREEN  = 4'd6;
  localparam logic [3:0] CTL_W_YELLOW = 4'd7;
  localparam logic [3:0] CTL_ALL_RED  = 4'd8;
  localparam logic [3:0] CTL_N_XING   = 4'd9;
  localparam logic [3:0] CTL_S_XING   = 4'd10;
  localparam logic [3:0] CTL_E_XING   = 4'd11;
  localparam logic [3:0] CTL_W_XING   = 4'd12;

  // ASCII characters
  localparam logic [7:0] ASCII_N     = 8'h4E;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_G     = 8'h47;
  localparam logic [7:0] ASCII_Y     = 8'h59;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_X     = 8'h58;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Frame geometry and handshake timeout
  localparam logic [2:0] LAST_IDX      = 3'd6;
  localparam logic [2:0] WAIT_HI_LIMIT = 3'd4;

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_state_t;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (ASCII_ZERO + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/telemetry_encoder.sv
// Combinational encoder: controller state/timer -> payload characters.
// Ports:
//   state  in  4  controller state code
//   timer  in  4  controller countdown value
//   dir    out 8  direction character
//   phase  out 8  phase character
//   digit  out 8  timer digit character
//   ckh    out 8  checksum upper nibble as ASCII hex
//   ckl    out 8  checksum lower nibble as ASCII hex
module telemetry_encoder
  import telemetry_framer_pkg::*;
(
  input  logic [3:0] state,
  input  logic [3:0] timer,
  output logic [7:0] dir,
  output logic [7:0] phase,
  output logic [7:0] digit,
  output logic [7:0] ckh,
  output logic [7:0] ckl
);

  logic [7:0] ck;

  // States 0-7 encode direction in bits [2:1] and green/yellow in bit 0.
  always_comb begin
    dir   = ASCII_QMARK;
    phase = ASCII_QMARK;
    if (state <= CTL_W_YELLOW) begin
      case (state[2:1])
        2'd0:    dir = ASCII_N;
        2'd1:    dir = ASCII_S;
        2'd2:    dir = ASCII_E;
        default: dir = ASCII_W;
      endcase
      phase = state[0] ? ASCII_Y : ASCII_G;
    end else if (state == CTL_ALL_RED) begin
      dir   = ASCII_A;
      phase = ASCII_T;
    end else if (state <= CTL_W_XING) begin
      phase = ASCII_X;
      case (state)
        CTL_N_XING: dir = ASCII_N;
        CTL_S_XING: dir = ASCII_S;
        CTL_E_XING: dir = ASCII_E;
        default:    dir = ASCII_W;
      endcase
    end
  end

  assign digit = (timer <= 4'd9) ? (ASCII_ZERO + {4'h0, timer}) : ASCII_QMARK;
  assign ck    = dir ^ phase ^ digit;
  assign ckh   = hex_ascii(ck[7:4]);
  assign ckl   = hex_ascii(ck[3:0]);

endmodule

// File: rtl/telemetry_framer.sv
// Telemetry framer: turns a controller snapshot into a 7-byte ASCII frame
// ($ DIR PHASE DIGIT CKH CKL LF) and feeds it byte by byte to a UART.
// Ports:
//   clk          in  1  system clock, rising edge
//   rst_n        in  1  synchronous active-low reset
//   snap_valid   in  1  one-cycle snapshot request
//   fsm_state    in  4  controller state, sampled with snap_valid
//   fsm_timer    in  4  controller countdown, sampled with snap_valid
//   tx_busy      in  1  UART busy flag
//   tx_data      out 8  byte presented to the UART
//   tx_start     out 1  one-cycle send strobe
//   frame_active out 1  high from first tx_start until EOL completes
//   overrun_cnt  out 8  saturating count of discarded snapshots
module telemetry_framer
  import telemetry_framer_pkg::*;
#(
  parameter logic [7:0] SOF_CHAR = SOF_DEFAULT,
  parameter logic [7:0] EOL_CHAR = EOL_DEFAULT
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       snap_valid,
  input  logic [3:0] fsm_state,
  input  logic [3:0] fsm_timer,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       frame_active,
  output logic [7:0] overrun_cnt
);

  tx_state_t  state, next_state;
  logic [2:0] idx;
  logic [2:0] wait_cnt;
  logic       load_byte;
  logic [2:0] load_sel;
  logic       eol_done;
  logic [7:0] byte_mux;
  logic       active;

  // cur_* is the snapshot being sent; pend_* is the single waiting slot
  logic       cur_valid, pend_valid;
  logic [3:0] cur_state, cur_timer, pend_state, pend_timer;

  logic [7:0] dir, phase, digit, ckh, ckl;

  telemetry_encoder u_encoder (
    .state (cur_state),
    .timer (cur_timer),
    .dir   (dir),
    .phase (phase),
    .digit (digit),
    .ckh   (ckh),
    .ckl   (ckl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // tx_start is asserted only while the UART reports idle, so a held START
  // simply waits. WAIT_HI gives up after WAIT_HI_LIMIT cycles and resends.
  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    load_byte  = 1'b0;
    load_sel   = idx;
    eol_done   = 1'b0;
    case (state)
      IDLE: begin
        if (cur_valid) begin
          load_byte  = 1'b1;
          load_sel   = 3'd0;
          next_state = START;
        end
      end
      START: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          next_state = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy)                                 next_state = WAIT_LO;
        else if (wait_cnt == WAIT_HI_LIMIT - 3'd1)   next_state = START;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            eol_done   = 1'b1;
            next_state = IDLE;
          end else begin
            load_byte  = 1'b1;
            load_sel   = idx + 3'd1;
            next_state = START;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    case (load_sel)
      3'd0:    byte_mux = SOF_CHAR;
      3'd1:    byte_mux = dir;
      3'd2:    byte_mux = phase;
      3'd3:    byte_mux = digit;
      3'd4:    byte_mux = ckh;
      3'd5:    byte_mux = ckl;
      default: byte_mux = EOL_CHAR;
    endcase
  end

  // A snapshot arriving on the EOL-completion edge is handled as if it had
  // arrived while the slot behind the current frame was being promoted, so
  // it is never counted as an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= 3'd0;
      wait_cnt    <= 3'd0;
      tx_data     <= 8'h00;
      active      <= 1'b0;
      overrun_cnt <= 8'h00;
      cur_valid   <= 1'b0;
      pend_valid  <= 1'b0;
      cur_state   <= 4'h0;
      cur_timer   <= 4'h0;
      pend_state  <= 4'h0;
      pend_timer  <= 4'h0;
    end else begin
      if (state == START)        wait_cnt <= 3'd0;
      else if (state == WAIT_HI) wait_cnt <= wait_cnt + 3'd1;

      if (load_byte) begin
        tx_data <= byte_mux;
        idx     <= load_sel;
      end else if (eol_done) begin
        idx <= 3'd0;
      end

      if (eol_done)      active <= 1'b0;
      else if (tx_start) active <= 1'b1;

      if (snap_valid) begin
        if (!cur_valid || (eol_done && !pend_valid)) begin
          cur_valid <= 1'b1;
          cur_state <= fsm_state;
          cur_timer <= fsm_timer;
        end else if (eol_done) begin
          cur_state  <= pend_state;
          cur_timer  <= pend_timer;
          pend_state <= fsm_state;
          pend_timer <= fsm_timer;
        end else begin
          pend_valid <= 1'b1;
          pend_state <= fsm_state;
          pend_timer <= fsm_timer;
          if (pend_valid && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
      end else if (eol_done) begin
        cur_valid  <= pend_valid;
        cur_state  <= pend_state;
        cur_timer  <= pend_timer;
        pend_valid <= 1'b0;
      end
    end
  end

  assign frame_active = active | tx_start;

endmodule
